// File: rtl/spi_out.sv
// SPI output shifter: frames {cmd_word, data_word} under active-low csb and shifts it MSB-first.
// Optional `SPI_OUT_QUEUE_EN adds a one-entry pending buffer so a start is accepted while busy.
module spi_out #(
   parameter int unsigned PACKET_WIDTH = 24,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned CSB_GAP      = 8
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic [7:0]            cmd_word,
   input  logic [DATA_WIDTH-1:0] data_word,
   input  logic                  start,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  csb
);

   localparam int unsigned BitW = $clog2(PACKET_WIDTH);
   localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast  = 8'(CSB_GAP - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(PACKET_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [BitW-1:0]         bit_q, bit_d;
   logic [PACKET_WIDTH-1:0] shreg_q, shreg_d;
   logic                    sclk_q, sclk_d;
   logic                    done_q, done_d;
   logic [PACKET_WIDTH-1:0] packet;
   logic                    accept;
   logic                    half_end;

   assign packet   = {cmd_word, data_word};
   assign accept   = start && ready;
   assign half_end = (cnt_q == HalfLast);

`ifdef SPI_OUT_QUEUE_EN
   logic [PACKET_WIDTH-1:0] pend_q, pend_d;
   logic                    pend_vld_q, pend_vld_d;

   assign ready = ~pend_vld_q;
`else
   assign ready = (state_q == StIdle);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sclk_d  = sclk_q;
      done_d  = 1'b0;
`ifdef SPI_OUT_QUEUE_EN
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (accept && state_q != StIdle) begin
         pend_d     = packet;
         pend_vld_d = 1'b1;
      end
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (accept) begin
               shreg_d = packet;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (half_end) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               state_d = StShift;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StShift: begin
            if (half_end) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               // Falling edge: advance data, except after the final bit.
               if (sclk_q) begin
                  if (bit_q == BitLast) begin
                     bit_d   = '0;
                     state_d = StHold;
                  end else begin
                     bit_d   = bit_q + BitW'(1);
                     shreg_d = {shreg_q[PACKET_WIDTH-2:0], 1'b0};
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StHold: begin
            if (half_end) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d   = '0;
               state_d = StIdle;
`ifdef SPI_OUT_QUEUE_EN
               // A start landing in the last gap cycle bypasses the buffer.
               if (pend_vld_q) begin
                  shreg_d    = pend_q;
                  pend_vld_d = 1'b0;
                  state_d    = StSetup;
               end else if (accept) begin
                  shreg_d    = packet;
                  pend_vld_d = 1'b0;
                  state_d    = StSetup;
               end
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_OUT_QUEUE_EN
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sclk_q  <= sclk_d;
         done_q  <= done_d;
`ifdef SPI_OUT_QUEUE_EN
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
`endif
      end
   end

   assign csb  = (state_q == StIdle) || (state_q == StGap);
   assign busy = (state_q != StIdle);
   assign sclk = sclk_q;
   assign done = done_q;
   assign mosi = ~csb & shreg_q[PACKET_WIDTH-1];

endmodule

// File: tb/tb_spi_out.sv
// Directed bench for spi_out: a CLK_DIV=4 instance for most scenarios, a CLK_DIV=1 instance for timing.
module tb_spi_out;

   localparam int H   = 4;
   localparam int GAP = 8;
   localparam int PKT = 49 * H;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic [7:0]  cmd    = '0;
   logic [15:0] data   = '0;
   logic        start  = 1'b0;
   logic        start1 = 1'b0;
   logic ready, busy, done, sclk, mosi, csb;
   logic ready1, busy1, done1, sclk1, mosi1, csb1;

   always #5 clk = ~clk;

   spi_out #(.PACKET_WIDTH(24), .DATA_WIDTH(16), .CLK_DIV(H), .CSB_GAP(GAP)) u_dut (
      .sys_clk(clk), .rst(rst), .cmd_word(cmd), .data_word(data), .start(start),
      .ready(ready), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .csb(csb)
   );

   spi_out #(.PACKET_WIDTH(24), .DATA_WIDTH(16), .CLK_DIV(1), .CSB_GAP(GAP)) u_dut1 (
      .sys_clk(clk), .rst(rst), .cmd_word(cmd), .data_word(data), .start(start1),
      .ready(ready1), .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .csb(csb1)
   );

   int errors = 0;
   int checks = 0;

   // Observations gathered by collect(); j counts samples taken #1 after each edge,
   // with j=0 right after the edge that accepted start.
   int          n_rise, rise_first_j, rise_last_j, csb_low_cnt, done_cnt, done_j;
   int          busy_low_j, gap_len, sclk_viol, rdy_busy;
   logic [63:0] bits;
   logic        j0_csb, j0_busy, j0_mosi;

   task automatic accept_pkt(input logic [23:0] p);
      int w = 0;
      @(negedge clk);
      while (!ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: ready=%b required 1", ready);
      end
      {cmd, data} = p;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic collect(input int ncyc, input int inj_j, input logic [23:0] inj_p);
      logic prev_sclk = 1'b0;
      logic prev_csb  = 1'b0;
      int   csb_up_j  = -1;
      n_rise = 0; rise_first_j = -1; rise_last_j = -1; csb_low_cnt = 0; done_cnt = 0;
      done_j = -1; busy_low_j = -1; gap_len = -1; sclk_viol = 0; rdy_busy = 0; bits = '0;
      for (int j = 0; j < ncyc; j++) begin
         if (j > 0) begin
            @(posedge clk);
            #1;
         end
         if (j == 0) begin
            j0_csb = csb; j0_busy = busy; j0_mosi = mosi;
         end
         if (sclk && !prev_sclk) begin
            if (n_rise == 0) rise_first_j = j;
            rise_last_j = j;
            n_rise++;
            bits = {bits[62:0], mosi};
         end
         if (sclk && csb) sclk_viol++;
         if (!csb) csb_low_cnt++;
         if (done) begin
            if (done_cnt == 0) done_j = j;
            done_cnt++;
         end
         if (!busy && busy_low_j < 0) busy_low_j = j;
         if (busy && ready) rdy_busy++;
         if (csb && !prev_csb) csb_up_j = j;
         if (!csb && prev_csb && csb_up_j >= 0 && gap_len < 0) gap_len = j - csb_up_j;
         prev_sclk = sclk;
         prev_csb  = csb;
         if (j == inj_j) begin
            {cmd, data} = inj_p;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
      checks++; if (csb !== 1'b1)   begin errors++; $display("FAIL reset_csb: got %b want 1", csb); end
      checks++; if (mosi !== 1'b0)  begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      accept_pkt(24'hA51234);
      collect(PKT + GAP + 4, -1, 24'h0);
      checks++; if (j0_csb !== 1'b0)  begin errors++; $display("FAIL basic_csb0: got %b want 0", j0_csb); end
      checks++; if (j0_busy !== 1'b1) begin errors++; $display("FAIL basic_busy0: got %b want 1", j0_busy); end
      checks++; if (j0_mosi !== 1'b1) begin errors++; $display("FAIL basic_mosi0: got %b want 1", j0_mosi); end
      checks++; if (n_rise != 24) begin errors++; $display("FAIL basic_rises: got %0d want 24", n_rise); end
      checks++; if (bits[23:0] !== 24'hA51234) begin errors++; $display("FAIL basic_bits: got %h want a51234", bits[23:0]); end
      checks++; if (rise_first_j != H) begin errors++; $display("FAIL basic_rise0: got %0d want %0d", rise_first_j, H); end
      checks++; if (rise_last_j != 47 * H) begin errors++; $display("FAIL basic_rise23: got %0d want %0d", rise_last_j, 47 * H); end
      checks++; if (csb_low_cnt != PKT) begin errors++; $display("FAIL basic_csb_low: got %0d want %0d", csb_low_cnt, PKT); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (done_j != PKT) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_j, PKT); end
      checks++; if (busy_low_j != PKT + GAP) begin errors++; $display("FAIL basic_busy_low: got %0d want %0d", busy_low_j, PKT + GAP); end
      checks++; if (sclk_viol != 0) begin errors++; $display("FAIL basic_sclk_csb: got %0d want 0", sclk_viol); end
   endtask

   task automatic test_clkdiv1();
      logic        prev = 1'b0;
      int          n = 0, bad = 0, up_j = -1, low_j = -1;
      logic [23:0] b = '0;
      @(negedge clk);
      {cmd, data} = 24'hFF0001;
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int j = 0; j < 64; j++) begin
         if (j > 0) begin
            @(posedge clk);
            #1;
         end
         if (sclk1 && !prev) begin
            if (j != 1 + 2 * n) bad++;
            n++;
            b = {b[22:0], mosi1};
         end
         prev = sclk1;
         if (csb1 && up_j < 0) up_j = j;
         if (!busy1 && low_j < 0) low_j = j;
      end
      checks++; if (n != 24) begin errors++; $display("FAIL div1_rises: got %0d want 24", n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL div1_rise_time: got %0d late rises want 0", bad); end
      checks++; if (b !== 24'hFF0001) begin errors++; $display("FAIL div1_bits: got %h want ff0001", b); end
      checks++; if (up_j != 49) begin errors++; $display("FAIL div1_csb_high: got %0d want 49", up_j); end
      checks++; if (low_j != 57) begin errors++; $display("FAIL div1_busy_low: got %0d want 57", low_j); end
   endtask

`ifdef SPI_OUT_QUEUE_EN
   task automatic test_back_to_back();
      accept_pkt(24'h010002);
      collect(2 * (PKT + GAP) + 4, 5, 24'h030004);
      checks++; if (n_rise != 48) begin errors++; $display("FAIL q_rises: got %0d want 48", n_rise); end
      checks++; if (bits[47:0] !== 48'h010002030004) begin errors++; $display("FAIL q_bits: got %h want 010002030004", bits[47:0]); end
      checks++; if (gap_len != GAP) begin errors++; $display("FAIL q_gap: got %0d want %0d", gap_len, GAP); end
      checks++; if (done_cnt != 2) begin errors++; $display("FAIL q_done_cnt: got %0d want 2", done_cnt); end
      checks++; if (busy_low_j != 2 * (PKT + GAP)) begin errors++; $display("FAIL q_busy_low: got %0d want %0d", busy_low_j, 2 * (PKT + GAP)); end
      checks++; if (csb_low_cnt != 2 * PKT) begin errors++; $display("FAIL q_csb_low: got %0d want %0d", csb_low_cnt, 2 * PKT); end
   endtask
`else
   task automatic test_ignore();
      accept_pkt(24'h5AC33C);
      collect(PKT + GAP + 20, 30, 24'h123456);
      checks++; if (n_rise != 24) begin errors++; $display("FAIL ign_rises: got %0d want 24", n_rise); end
      checks++; if (bits[23:0] !== 24'h5AC33C) begin errors++; $display("FAIL ign_bits: got %h want 5ac33c", bits[23:0]); end
      checks++; if (csb_low_cnt != PKT) begin errors++; $display("FAIL ign_csb_low: got %0d want %0d", csb_low_cnt, PKT); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (rdy_busy != 0) begin errors++; $display("FAIL ign_ready: got %0d busy-ready cycles want 0", rdy_busy); end
      checks++; if (busy_low_j != PKT + GAP) begin errors++; $display("FAIL ign_busy_low: got %0d want %0d", busy_low_j, PKT + GAP); end
   endtask
`endif

   task automatic test_abort();
      logic prev = 1'b0;
      int   n = 0, w = 0, d = 0;
      accept_pkt(24'h0F0F0F);
      while (n < 10 && w < 400) begin
         @(posedge clk);
         #1;
         if (sclk && !prev) n++;
         prev = sclk;
         w++;
      end
      checks++;
      if (n != 10) begin errors++; $display("FAIL abort_reach_rise10: got %0d rises want 10", n); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (csb !== 1'b1)  begin errors++; $display("FAIL abort_csb: got %b want 1", csb); end
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b want 0", sclk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) d++;
         @(posedge clk);
         #1;
      end
      checks++; if (d != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", d); end
      accept_pkt(24'hC0FFEE);
      collect(PKT + GAP + 4, -1, 24'h0);
      checks++; if (n_rise != 24) begin errors++; $display("FAIL abort_fresh_rises: got %0d want 24", n_rise); end
      checks++; if (bits[23:0] !== 24'hC0FFEE) begin errors++; $display("FAIL abort_fresh_bits: got %h want c0ffee", bits[23:0]); end
   endtask

   // Receiver model: capture mosi on each sclk rise, split into command and data words.
   task automatic test_loopback();
      logic [7:0]  rx_cmd;
      logic [15:0] rx_data;
      accept_pkt(24'h7EBEEF);
      collect(PKT + GAP + 4, -1, 24'h0);
      rx_cmd  = bits[23:16];
      rx_data = bits[15:0];
      checks++; if (rx_cmd !== 8'h7E) begin errors++; $display("FAIL loop_cmd: got %h want 7e", rx_cmd); end
      checks++; if (rx_data !== 16'hBEEF) begin errors++; $display("FAIL loop_data: got %h want beef", rx_data); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL loop_valid: got %0d pulses want 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clkdiv1();
`ifdef SPI_OUT_QUEUE_EN
      test_back_to_back();
`else
      test_ignore();
`endif
      test_abort();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
